// File: rtl/seg_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder_if
// Multiplexed 7-segment display bus: digit select plus segment pattern.
//
// Signals:
//   seg_com   [DIGITS-1:0]  digit select, active-low; one 0 selects a digit,
//                           all ones means blank
//   seg_data  [7:0]         segment pattern, active-high; bit0=a .. bit6=g,
//                           bit7=dp
// Modports:
//   master  display driver side (drives the pins)
//   slave   monitor side (observes the pins)
// -----------------------------------------------------------------------------
interface seg_scan_decoder_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS-1:0] seg_com;
    logic [7:0]        seg_data;

    modport master (output seg_com, output seg_data);
    modport slave  (input  seg_com, input  seg_data);
endinterface

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Monitors a multiplexed 7-segment display bus and recovers the BCD value,
// valid flag and decimal point of every digit position. A (seg_com, seg_data)
// pair is committed once after STABLE_CYCLES identical samples; illegal
// patterns and multi-select are flagged, completed scan frames are signalled,
// and all digits are marked stale if nothing is committed for TIMEOUT cycles.
//
// Ports:
//   mclk         in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   bus          slave modport of seg_scan_decoder_if (seg_com, seg_data)
//   digits       out  4*DIGITS  decoded BCD, digit i in [4i+3:4i]
//   digit_valid  out  DIGITS    digit i holds a fresh, legal value
//   dp           out  DIGITS    dp bit from the last legal commit of digit i
//   frame_done   out  1         pulse: every digit committed since last pulse
//   seg_err      out  1         pulse: committed pattern is not a digit
//   com_err      out  1         pulse: committed seg_com has several 0s
//   stale        out  1         pulse: timeout fired
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65535
) (
    input  logic                  mclk,
    input  logic                  rst,
    seg_scan_decoder_if.slave     bus,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     dp,
    output logic                  frame_done,
    output logic                  seg_err,
    output logic                  com_err,
    output logic                  stale
);

    localparam int         IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int         TO_W  = $clog2(TIMEOUT);
    localparam logic [7:0] STAB  = 8'(STABLE_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    // Returns {legal, value}; bit7 (dp) is not part of the digit shape.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'h3F:   decode_seg = {1'b1, 4'd0};
            7'h06:   decode_seg = {1'b1, 4'd1};
            7'h5B:   decode_seg = {1'b1, 4'd2};
            7'h4F:   decode_seg = {1'b1, 4'd3};
            7'h66:   decode_seg = {1'b1, 4'd4};
            7'h6D:   decode_seg = {1'b1, 4'd5};
            7'h7D:   decode_seg = {1'b1, 4'd6};
            7'h07:   decode_seg = {1'b1, 4'd7};
            7'h7F:   decode_seg = {1'b1, 4'd8};
            7'h67,
            7'h6F:   decode_seg = {1'b1, 4'd9};
            default: decode_seg = 5'b0_0000;
        endcase
    endfunction

    // Input sample S, and the previous sample P used for the stability compare.
    logic [DIGITS-1:0] r_s_com, r_p_com;
    logic [7:0]        r_s_data, r_p_data;
    logic              r_s_vld, r_p_vld;
    logic [7:0]        r_stab_cnt;
    logic              r_commit;       // P holds the pair being committed
    logic [DIGITS-1:0] r_seen;
    logic [TO_W-1:0]   r_to_cnt;

    logic [DIGITS-1:0] w_low;
    logic              w_blank, w_onehot, w_multi, w_hit, w_timeout;
    logic [IDX_W-1:0]  w_idx;
    logic [4:0]        w_dec;
    logic [7:0]        w_stab_next;
    logic [DIGITS-1:0] w_seen_next;

    assign w_low     = ~r_p_com;
    assign w_blank   = (w_low == '0);
    assign w_onehot  = !w_blank && ((w_low & (w_low - 1'b1)) == '0);
    assign w_multi   = !w_blank && !w_onehot;
    assign w_hit     = r_commit && w_onehot;
    assign w_timeout = !w_hit && (r_to_cnt == TO_LAST);
    assign w_dec     = decode_seg(r_p_data[6:0]);

    // NOTE: every combinational output gets a default before any condition,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_low[i]) w_idx = IDX_W'(i);
        end
    end

    // A run starts at 1 on any change or on the first sample after reset,
    // then saturates at STABLE_CYCLES.
    always_comb begin
        w_stab_next = 8'd1;
        if (r_p_vld && r_s_com == r_p_com && r_s_data == r_p_data) begin
            w_stab_next = (r_stab_cnt == STAB) ? STAB : r_stab_cnt + 8'd1;
        end
    end

    // A full mask is cleared one cycle late (with frame_done); a commit in
    // that cycle lands in the fresh mask.
    always_comb begin
        w_seen_next = (&r_seen) ? '0 : r_seen;
        if (w_hit) begin
            w_seen_next[w_idx] = 1'b1;
        end else if (w_timeout) begin
            w_seen_next = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge mclk) begin
        // NOTE: every register, outputs included, is cleared by reset; there
        // is no storage here that is allowed to power up undefined.
        if (rst) begin
            r_s_com     <= '0;
            r_s_data    <= '0;
            r_s_vld     <= 1'b0;
            r_p_com     <= '0;
            r_p_data    <= '0;
            r_p_vld     <= 1'b0;
            r_stab_cnt  <= '0;
            r_commit    <= 1'b0;
            r_seen      <= '0;
            r_to_cnt    <= '0;
            digits      <= '0;
            digit_valid <= '0;
            dp          <= '0;
            frame_done  <= 1'b0;
            seg_err     <= 1'b0;
            com_err     <= 1'b0;
            stale       <= 1'b0;
        end else begin
            r_s_com  <= bus.seg_com;
            r_s_data <= bus.seg_data;
            r_s_vld  <= 1'b1;
            r_p_com  <= r_s_com;
            r_p_data <= r_s_data;
            r_p_vld  <= r_s_vld;

            if (r_s_vld) begin
                r_stab_cnt <= w_stab_next;
                // Commit only on the edge the count reaches the threshold.
                r_commit   <= (w_stab_next == STAB) && (r_stab_cnt != STAB);
            end else begin
                r_commit   <= 1'b0;
            end

            frame_done <= &r_seen;
            seg_err    <= 1'b0;
            com_err    <= 1'b0;
            stale      <= 1'b0;
            r_seen     <= w_seen_next;

            if (w_hit) begin
                r_to_cnt <= '0;
                if (w_dec[4]) begin
                    digits[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
                    digit_valid[w_idx]          <= 1'b1;
                    dp[w_idx]                   <= r_p_data[7];
                end else begin
                    digit_valid[w_idx] <= 1'b0;
                    seg_err            <= 1'b1;
                end
            end else if (w_timeout) begin
                r_to_cnt    <= '0;
                stale       <= 1'b1;
                digit_valid <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (r_commit && w_multi) begin
                com_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Self-checking bench for seg_scan_decoder (DIGITS=8, STABLE_CYCLES=4,
// TIMEOUT=20). A reference model built from run lengths, a commit queue and
// per-digit arrays is compared against every output after every edge;
// directed sequences and a vector table add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int DIGITS = 8;
    localparam int STAB   = 4;
    localparam int TMO    = 20;

    logic mclk = 1'b0;
    logic rst  = 1'b1;
    always #5 mclk = ~mclk;

    seg_scan_decoder_if #(.DIGITS(DIGITS)) bus();

    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   digit_valid, dp;
    logic                frame_done, seg_err, com_err, stale;

    seg_scan_decoder #(
        .DIGITS(DIGITS), .STABLE_CYCLES(STAB), .TIMEOUT(TMO)
    ) dut (
        .mclk(mclk), .rst(rst), .bus(bus),
        .digits(digits), .digit_valid(digit_valid), .dp(dp),
        .frame_done(frame_done), .seg_err(seg_err), .com_err(com_err),
        .stale(stale)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                due;
        logic [DIGITS-1:0] com;
        logic [7:0]        data;
    } pend_t;

    pend_t             m_q[$];
    int                m_edge = 0;
    int                m_run  = 0;
    logic [DIGITS-1:0] m_lcom;
    logic [7:0]        m_ldata;
    logic [3:0]        m_dig[DIGITS];
    logic [DIGITS-1:0] m_valid, m_dp, m_seen;
    int                m_since;
    logic              m_fd, m_se, m_ce, m_st;

    function automatic int ref_value(input logic [6:0] p);
        case (p)
            7'h3F: return 0;  7'h06: return 1;  7'h5B: return 2;
            7'h4F: return 3;  7'h66: return 4;  7'h6D: return 5;
            7'h7D: return 6;  7'h07: return 7;  7'h7F: return 8;
            7'h67: return 9;  7'h6F: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic model_step();
        pend_t p;
        int    zeros, idx, v;
        logic  hit;
        m_edge++;
        m_fd = 0; m_se = 0; m_ce = 0; m_st = 0;
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = '0;
            m_valid = '0; m_dp = '0; m_seen = '0; m_since = 0;
            m_run = 0; m_q.delete();
            return;
        end
        // Pair seen at this edge; run of STAB identical samples commits,
        // with the visible update two edges after the STAB-th sample.
        if (m_run == 0 || bus.seg_com != m_lcom || bus.seg_data != m_ldata) m_run = 1;
        else m_run++;
        m_lcom  = bus.seg_com;
        m_ldata = bus.seg_data;
        if (m_run == STAB) m_q.push_back('{m_edge + 2, bus.seg_com, bus.seg_data});

        hit = 0;
        if (m_seen == '1) begin
            m_fd   = 1;
            m_seen = '0;
        end
        if (m_q.size() > 0 && m_q[0].due == m_edge) begin
            p = m_q.pop_front();
            zeros = 0; idx = 0;
            for (int i = 0; i < DIGITS; i++) if (!p.com[i]) begin zeros++; idx = i; end
            if (zeros == 1) begin
                hit = 1;
                v = ref_value(p.data[6:0]);
                if (v >= 0) begin
                    m_dig[idx]   = 4'(v);
                    m_valid[idx] = 1'b1;
                    m_dp[idx]    = p.data[7];
                end else begin
                    m_valid[idx] = 1'b0;
                    m_se = 1;
                end
                m_seen[idx] = 1'b1;
                m_since = 0;
            end else if (zeros > 1) begin
                m_ce = 1;
            end
        end
        if (!hit) begin
            m_since++;
            if (m_since == TMO) begin
                m_st = 1; m_valid = '0; m_seen = '0; m_since = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [4*DIGITS-1:0] exp_dig;
        for (int i = 0; i < DIGITS; i++) exp_dig[4*i +: 4] = m_dig[i];
        check("digits",      digits,      exp_dig);
        check("digit_valid", digit_valid, m_valid);
        check("dp",          dp,          m_dp);
        check("frame_done",  frame_done,  m_fd);
        check("seg_err",     seg_err,     m_se);
        check("com_err",     com_err,     m_ce);
        check("stale",       stale,       m_st);
    endtask

    // Pulse tallies for the directed sequences.
    int n_fd = 0, n_se = 0, n_ce = 0, n_st = 0;

    task automatic cyc();
        @(posedge mclk);
        #1;
        model_step();
        compare_all();
        if (frame_done) n_fd++;
        if (seg_err)    n_se++;
        if (com_err)    n_ce++;
        if (stale)      n_st++;
    endtask

    task automatic hold(input logic [DIGITS-1:0] com, input logic [7:0] data, input int n);
        bus.seg_com  = com;
        bus.seg_data = data;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr_tally();
        n_fd = 0; n_se = 0; n_ce = 0; n_st = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DIGITS-1:0] com;
        logic [7:0]        data;
        int                idx;
        logic [3:0]        exp_val;
        logic              exp_valid;
        logic              exp_dp;
    } vec_t;

    vec_t vt[9];

    logic [7:0] scan_pat[8];
    logic [7:0] legal_pat[11];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int v7_cyc, fd_cyc, cc, k;
        logic [DIGITS-1:0] rc;
        logic [7:0] rd;

        vt[0] = '{8'hDF, 8'hE7, 5, 4'd9, 1'b1, 1'b1};
        vt[1] = '{8'hDF, 8'h6F, 5, 4'd9, 1'b1, 1'b0};
        vt[2] = '{8'hF7, 8'h67, 3, 4'd9, 1'b1, 1'b0};
        vt[3] = '{8'hEF, 8'h3F, 4, 4'd0, 1'b1, 1'b0};
        vt[4] = '{8'hBF, 8'h7D, 6, 4'd6, 1'b1, 1'b0};
        vt[5] = '{8'hFE, 8'h87, 0, 4'd7, 1'b1, 1'b1};
        vt[6] = '{8'hFD, 8'h6D, 1, 4'd5, 1'b1, 1'b0};
        vt[7] = '{8'hFD, 8'h80, 1, 4'd5, 1'b0, 1'b0};
        vt[8] = '{8'h7F, 8'hFF, 7, 4'd8, 1'b1, 1'b1};

        scan_pat = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
        legal_pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D,
                      8'h07, 8'h7F, 8'h67, 8'h6F};

        // Reset
        bus.seg_com  = '1;
        bus.seg_data = '0;
        rst = 1'b1;
        cyc(); cyc();
        check("reset_digits", digits, 32'h0);
        check("reset_valid",  digit_valid, 8'h00);
        check("reset_dp",     dp, 8'h00);
        check("reset_pulses", {frame_done, seg_err, com_err, stale}, 4'b0);

        // First commit: update lands on the 6th edge after the first drive edge
        rst = 1'b0;
        clr_tally();
        bus.seg_com  = 8'hFE;
        bus.seg_data = 8'h3F;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 5) check("first_commit_early", digit_valid, 8'h00);
            if (i == 6) check("first_commit_valid", digit_valid, 8'h01);
        end
        check("first_commit_value", digits[3:0], 4'd0);
        check("first_commit_errs",  n_se + n_ce, 0);

        // Full scan 1..8
        clr_tally();
        v7_cyc = -1; fd_cyc = -1; cc = 0;
        for (int d = 0; d < 8; d++) begin
            bus.seg_com  = ~(8'h01 << d);
            bus.seg_data = scan_pat[d];
            for (int i = 0; i < 6; i++) begin
                cyc(); cc++;
                if (digit_valid[7] && v7_cyc < 0) v7_cyc = cc;
                if (frame_done) fd_cyc = cc;
            end
        end
        bus.seg_com = '1; bus.seg_data = '0;
        for (int i = 0; i < 3; i++) begin
            cyc(); cc++;
            if (frame_done) fd_cyc = cc;
        end
        check("scan_digits",     digits, 32'h87654321);
        check("scan_valid",      digit_valid, 8'hFF);
        check("scan_frame_cnt",  n_fd, 1);
        check("scan_frame_time", fd_cyc, v7_cyc + 1);

        // Glitch on digit 2: no commit while toggling, then settle on 3
        hold(8'hFB, 8'h3F, 6);
        check("glitch_pre", digits[11:8], 4'd0);
        clr_tally();
        for (int t = 0; t < 6; t++) hold(8'hFB, (t % 2) ? 8'h5B : 8'h06, 2);
        check("glitch_hold", digits[11:8], 4'd0);
        check("glitch_errs", n_se, 0);
        bus.seg_data = 8'h4F;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 5) check("glitch_not_yet", digits[11:8], 4'd0);
            if (i == 6) check("glitch_settled", digits[11:8], 4'd3);
        end

        // Illegal pattern, then multi-select
        clr_tally();
        hold(8'hFB, 8'h49, 6);
        check("illegal_seg_err", n_se, 1);
        check("illegal_valid2",  digit_valid[2], 1'b0);
        check("illegal_keep",    digits[11:8], 4'd3);
        clr_tally();
        hold(8'hF3, 8'h4F, 6);
        check("multi_com_err", n_ce, 1);

        // Vector table
        foreach (vt[j]) begin
            hold(vt[j].com, vt[j].data, 6);
            check($sformatf("vec%0d_val", j),   digits[4*vt[j].idx +: 4], vt[j].exp_val);
            check($sformatf("vec%0d_valid", j), digit_valid[vt[j].idx],  vt[j].exp_valid);
            check($sformatf("vec%0d_dp", j),    dp[vt[j].idx],           vt[j].exp_dp);
        end

        // Timeout: stale 20 cycles after the last commit
        hold(8'hF7, 8'h66, 6);
        check("timeout_pre", digits[15:12], 4'd4);
        bus.seg_com = '1; bus.seg_data = '0;
        k = 0;
        clr_tally();
        while (k < 40 && n_st == 0) begin
            cyc(); k++;
        end
        check("timeout_delay", k, 20);
        check("timeout_valid", digit_valid, 8'h00);
        check("timeout_keep",  digits[15:12], 4'd4);

        // Reset mid-run discards the partial run
        hold(8'hFD, 8'h5B, 3);
        rst = 1'b1;
        cyc();
        check("midreset_digits", digits, 32'h0);
        check("midreset_valid",  digit_valid, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 5) check("midreset_early", digit_valid[1], 1'b0);
            if (i == 6) check("midreset_commit", digit_valid[1], 1'b1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 160; n++) begin
            k = $urandom_range(0, 11);
            if (k == 0) begin
                rc = '1;
            end else if (k == 1) begin
                int a, b;
                a  = $urandom_range(0, 7);
                b  = (a + $urandom_range(1, 7)) % 8;
                rc = ~((8'h01 << a) | (8'h01 << b));
            end else begin
                rc = ~(8'h01 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) < 7) begin
                rd = legal_pat[$urandom_range(0, 10)];
                rd[7] = 1'($urandom_range(0, 1));
            end else begin
                rd = 8'($urandom);
            end
            if (k == 2 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            hold(rc, rd, $urandom_range(1, 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads a multiplexed 7-segment display bus (digit-select plus segment pattern) and recovers the BCD digit value, valid flag and decimal point for each digit position.
- Sits on the display pins as a monitor or self-check block for the BCD counter and display drivers in this design.
- Applies a stability filter, reports illegal patterns, signals each completed scan frame, and marks data stale when scanning stops.

Parameters:
- DIGITS, 8, number of digit positions; sets the widths of seg_com, digits, digit_valid and dp.
- STABLE_CYCLES, 4, consecutive identical samples required before a (seg_com, seg_data) pair is committed; legal range 2..255.
- TIMEOUT, 65535, mclk cycles without a commit before all digit_valid bits are cleared; legal range ≥ 2.

Ports:
- mclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_com  in  DIGITS  digit select, active-low; exactly one 0 selects a digit; all ones means blank.
- seg_data  in  8  segment pattern, active-high; bit0=a … bit6=g, bit7=dp.
- digits  out  4*DIGITS  decoded BCD values; digit i is in bits [4i+3:4i].
- digit_valid  out  DIGITS  bit i = digit i holds a decoded value that is neither invalid nor stale.
- dp  out  DIGITS  dp bit captured at the last valid commit of digit i.
- frame_done  out  1  one-cycle pulse: every digit has been committed since the last frame_done.
- seg_err  out  1  one-cycle pulse: committed pattern is not a legal digit.
- com_err  out  1  one-cycle pulse: committed seg_com has more than one 0.
- stale  out  1  one-cycle pulse when the timeout fires.

Behaviour:
- Reset (rst=1 at an edge): all outputs and internal registers go to 0, including digits, digit_valid, dp, all pulses, the input sample register, stab_cnt, the seen mask and the timeout counter.
- Input stage: seg_com and seg_data are registered once (sample S). No other synchronisation is applied.
- Stability counter stab_cnt, saturating at STABLE_CYCLES:
  - S equal to the previous S: stab_cnt increments.
  - S different: stab_cnt loads 1.
  - First sample after reset: stab_cnt loads 1.
- Commit event: occurs on the single cycle stab_cnt becomes STABLE_CYCLES. There is exactly one commit per stable run, however long the run lasts.
- Latency: a pair held at the inputs from edge k produces its output update at edge k+STABLE_CYCLES+1.
- Decode table (bits 6:0 → value): 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x67→9, 0x6F→9. Bit7 is excluded from the decode.
- Handling at a commit:
  - seg_com all ones: no update and no error pulse. The timeout counter is not reset.
  - More than one 0 in seg_com: com_err pulses; no digit update.
  - One-hot-low seg_com selecting digit i, legal pattern: digits[i] loads the value, digit_valid[i]=1, dp[i]=bit7, and seen[i] is set.
  - One-hot-low seg_com selecting digit i, illegal pattern: seg_err pulses, digit_valid[i]=0, digits[i] and dp[i] keep their values, and seen[i] is set.
- Frame detection:
  - When seen becomes all ones, frame_done pulses on the next cycle and seen clears to 0.
  - A commit in that same cycle lands in the cleared mask and counts toward the next frame.
  - A digit committed twice within one frame is not an error.
- Timeout:
  - The counter resets on every commit with a one-hot-low seg_com, whether the pattern is legal or illegal.
  - Otherwise it increments.
  - On reaching TIMEOUT: stale pulses, digit_valid clears to all 0, seen clears, and the counter restarts from 0. digits and dp hold their values.
  - A commit in the same cycle as the timeout wins: the timeout is suppressed.
- Reset asserted mid-run discards any partial stability run and the seen mask. The stability run restarts once rst is deasserted.

Test Plan:
- Reset, then drive seg_com=0xFE, seg_data=0x3F for 10 cycles → digits[3:0]=0, digit_valid=0x01 at edge STABLE_CYCLES+1 (5) after the first drive edge; no error pulses.
- Scan digits 0..7 with patterns for 1,2,…,8, holding each for 6 cycles → digits=0x87654321, digit_valid=0xFF, exactly one frame_done pulse 1 cycle after the digit-7 commit.
- Glitch: seg_data toggles 0x06/0x5B every 2 cycles on digit 2, then settles at 0x4F → no commit during toggling; digits[11:8]=3 only after 4 stable samples.
- Illegal pattern: seg_com=0xFB, seg_data=0x49 held 6 cycles → seg_err pulses once; digit_valid[2]=0; digits[11:8] unchanged. Then seg_com=0xF3 held 6 cycles → com_err pulses once.
- Decimal point: seg_data=0xE7 on digit 5 → digits[23:20]=9, dp[5]=1. Both 0x67 and 0x6F on bits 6:0 yield 9.
- Timeout: with TIMEOUT=20, commit one digit, then hold seg_com=0xFF → stale pulses 20 cycles after the last commit; digit_valid=0; digits retained.
